// File: rtl/riscv_pkg.sv
// riscv_pkg: shared ALU opcodes, forward selects and the forwarding mux helper
package riscv_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] rf, input logic [31:0] wb, input logic [31:0] mem);
    return sel == FWD_WB ? wb : sel == FWD_MEM ? mem : rf;
  endfunction
endpackage

// File: rtl/alu.sv
// alu: add/sub/and/or/signed-slt datapath with zero flag
module alu
  import riscv_pkg::*;
(
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [2:0]  ALUControl,
  output logic [31:0] Result,
  output logic        Zero
);
  // unused opcodes fall through to zero
  always_comb begin
    Result = ALUControl == ALU_ADD ? SrcA + SrcB :
             ALUControl == ALU_SUB ? SrcA - SrcB :
             ALUControl == ALU_AND ? SrcA & SrcB :
             ALUControl == ALU_OR  ? SrcA | SrcB :
             ALUControl == ALU_SLT ? {31'b0, $signed(SrcA) < $signed(SrcB)} : 32'h0;
  end
  assign Zero = Result == 32'h0;
endmodule

// File: rtl/execute_cycle.sv
// execute_cycle: EX stage with operand forwarding, ALU, branch resolve and EX/MEM register
module execute_cycle
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [4:0]  RD_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [1:0]  ForwardA_E,
  input  logic [1:0]  ForwardB_E,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] PCPlus4M,
  output logic [31:0] WriteDataM,
  output logic [31:0] ALUResultM
);
  logic [31:0] src_a, src_b, write_data, alu_result;
  logic        zero;
  assign src_a      = fwd_mux(ForwardA_E, RD1_E, ResultW, ALUResultM);
  assign write_data = fwd_mux(ForwardB_E, RD2_E, ResultW, ALUResultM);
  assign src_b      = ALUSrcE ? Imm_Ext_E : write_data;
  alu u_alu (
    .SrcA(src_a),
    .SrcB(src_b),
    .ALUControl(ALUControlE),
    .Result(alu_result),
    .Zero(zero)
  );
  assign PCSrcE    = BranchE & zero;
  assign PCTargetE = PCE + Imm_Ext_E;
  // EX/MEM register: captures every edge, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      RD_M       <= 5'd0;
      PCPlus4M   <= 32'h0;
      WriteDataM <= 32'h0;
      ALUResultM <= 32'h0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RD_M       <= RD_E;
      PCPlus4M   <= PCPlus4E;
      WriteDataM <= write_data;
      ALUResultM <= alu_result;
    end
  end
endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: directed table, hand sequences and random stimulus against a reference model
module tb_execute_cycle;
  logic clk = 1'b0, rst = 1'b0;
  logic RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0] ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0] RD_E;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic PCSrcE, RegWriteM, MemWriteM, ResultSrcM;
  logic [31:0] PCTargetE, PCPlus4M, WriteDataM, ALUResultM;
  logic [4:0] RD_M;
  int checks = 0, failures = 0;
  logic [31:0] model_alum = 32'h0;

  typedef struct {
    logic regw, alusrc, memw, ressrc, br;
    logic [2:0] ctl;
    logic [1:0] fa, fb;
    logic [4:0] rd;
    logic [31:0] rd1, rd2, imm, pc, resw;
    logic pcsrc;
    logic [31:0] tgt, alum, wdm;
  } vec_t;

  execute_cycle dut (
    .clk(clk), .rst(rst), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE), .RD1_E(RD1_E),
    .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALUResultM(ALUResultM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s #%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return sa < sb ? 32'h1 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] f, input logic [31:0] rf, input logic [31:0] wb);
    return f == 2'd1 ? wb : f == 2'd2 ? model_alum : rf;
  endfunction

  function automatic vec_t fill(input vec_t v);
    vec_t r = v;
    logic [31:0] a, wd, res;
    a = pick(v.fa, v.rd1, v.resw);
    wd = pick(v.fb, v.rd2, v.resw);
    res = ref_alu(v.ctl, a, v.alusrc ? v.imm : wd);
    r.alum = res;
    r.wdm = wd;
    r.pcsrc = v.br && res == 32'h0;
    r.tgt = v.pc + v.imm;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    RegWriteE = v.regw; ALUSrcE = v.alusrc; MemWriteE = v.memw; ResultSrcE = v.ressrc; BranchE = v.br;
    ALUControlE = v.ctl; ForwardA_E = v.fa; ForwardB_E = v.fb; RD_E = v.rd;
    RD1_E = v.rd1; RD2_E = v.rd2; Imm_Ext_E = v.imm; PCE = v.pc; PCPlus4E = v.pc + 32'd4; ResultW = v.resw;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    drive(v);
    #1;
    chk("pcsrc", idx, {31'b0, PCSrcE}, {31'b0, v.pcsrc});
    chk("pctarget", idx, PCTargetE, v.tgt);
    @(posedge clk);
    #1;
    chk("aluresult_m", idx, ALUResultM, v.alum);
    chk("writedata_m", idx, WriteDataM, v.wdm);
    chk("rd_m", idx, {27'b0, RD_M}, {27'b0, v.rd});
    chk("ctl_m", idx, {29'b0, RegWriteM, MemWriteM, ResultSrcM}, {29'b0, v.regw, v.memw, v.ressrc});
    chk("pcplus4_m", idx, PCPlus4M, v.pc + 32'd4);
    model_alum = v.alum;
  endtask

  task automatic chk_reset_state(input int idx);
    chk("rst_aluresult_m", idx, ALUResultM, 32'h0);
    chk("rst_writedata_m", idx, WriteDataM, 32'h0);
    chk("rst_pcplus4_m", idx, PCPlus4M, 32'h0);
    chk("rst_rd_m", idx, {27'b0, RD_M}, 32'h0);
    chk("rst_ctl_m", idx, {29'b0, RegWriteM, MemWriteM, ResultSrcM}, 32'h0);
  endtask

  vec_t vecs[11];
  vec_t v;

  initial begin
    vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,2'd0,2'd0,5'd3, 32'd5,32'd0,32'd7,32'h0,32'd0, 1'b0,32'd7,32'd12,32'd0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,3'd1,2'd0,2'd0,5'd4, 32'd10,32'd3,32'd0,32'h20,32'd0, 1'b0,32'h20,32'd7,32'd3};
    vecs[2]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,3'd2,2'd2,2'd1,5'd5, 32'd99,32'd55,32'd0,32'h24,32'd2, 1'b0,32'h24,32'd2,32'd2};
    vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'd5,2'd0,2'd0,5'd6, 32'hFFFFFFFF,32'd0,32'd1,32'h0,32'd0, 1'b0,32'd1,32'd1,32'd0};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd5,2'd0,2'd0,5'd7, 32'd1,32'hFFFFFFFF,32'd0,32'h0,32'd0, 1'b0,32'd0,32'd0,32'hFFFFFFFF};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,3'd1,2'd0,2'd0,5'd0, 32'd9,32'd9,32'hFFFFFFF8,32'h100,32'd0, 1'b1,32'hF8,32'd0,32'd9};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,3'd1,2'd0,2'd0,5'd0, 32'd9,32'd8,32'hFFFFFFF8,32'h100,32'd0, 1'b0,32'hF8,32'd1,32'd8};
    vecs[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,2'd0,2'd0,5'd8, 32'hFFFFFFFF,32'd0,32'd1,32'h0,32'd0, 1'b0,32'd1,32'd0,32'd0};
    vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,2'd3,2'd0,5'd9, 32'd6,32'd0,32'd4,32'h0,32'd100, 1'b0,32'd4,32'd10,32'd0};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,2'd2,2'd2,5'd10, 32'd0,32'd0,32'd0,32'h0,32'd0, 1'b0,32'd0,32'd20,32'd10};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b0,1'b1,3'd4,2'd0,2'd0,5'd0, 32'd3,32'd0,32'd5,32'h0,32'd0, 1'b1,32'd5,32'd0,32'd0};
    drive(vecs[0]);
    #2;
    chk_reset_state(0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);
    for (int i = 0; i < 300; i++) begin
      v.regw = 1'($urandom); v.alusrc = 1'($urandom); v.memw = 1'($urandom);
      v.ressrc = 1'($urandom); v.br = 1'($urandom);
      v.ctl = 3'($urandom); v.fa = 2'($urandom); v.fb = 2'($urandom); v.rd = 5'($urandom);
      v.rd1 = $urandom; v.rd2 = ($urandom_range(0, 3) == 0) ? v.rd1 : $urandom;
      v.imm = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      v.pc = $urandom; v.resw = ($urandom_range(0, 3) == 0) ? v.rd1 : $urandom;
      run_vec(fill(v), 100 + i);
    end
    v = '{1'b1,1'b1,1'b1,1'b1,1'b0,3'd0,2'd0,2'd0,5'd17, 32'd40,32'd77,32'd2,32'h300,32'd0, 1'b0,32'd0,32'd0,32'd0};
    run_vec(fill(v), 500);
    rst = 1'b0;
    #1;
    chk_reset_state(501);
    chk("rst_pctarget", 501, PCTargetE, 32'h302);
    @(posedge clk);
    #1;
    chk_reset_state(502);
    @(negedge clk);
    rst = 1'b1;
    model_alum = 32'h0;
    v.fa = 2'd2;
    v.fb = 2'd2;
    v.alusrc = 1'b0;
    run_vec(fill(v), 503);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
